systolic_os_array: RTL and testbench

Parametrised output-stationary systolic matrix-multiply engine, the next generation of the team's fixed 4x4 MAC array. It accepts K beats of A-column and B-row vectors through a valid/ready stream and skews them internally, so the feeder needs no pre-staggering. Each of ROWS x COLS processing elements accumulates one C element. Results drain one row per handshake to the writeback stage.

---
 rtl/systolic_os_array.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_systolic_os_array.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_os_array.sv
// systolic_os_array
//
// Output-stationary ROWS x COLS matrix-multiply engine. A job streams K beats,
// each carrying one A column (in_left) and one B row (in_top). The engine skews
// the operands internally so PE(r,c) sees beat k at the same time on both
// inputs. Each PE accumulates one C element. Rows are then drained one per
// out_valid/out_ready handshake.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   i_start         start a job (sampled only while idle)
//   i_k_len         beats in the job (sampled with i_start)
//   i_signed        1 = two's-complement operands (sampled with i_start)
//   in_valid        operand beat valid
//   in_ready        engine accepts a beat (high only while loading)
//   in_left         A column, slice r feeds array row r
//   in_top          B row, slice c feeds array column c
//   out_valid       result row valid
//   out_ready       consumer accepts the row
//   out_row         C row, slice c = C[out_row_idx][c]
//   out_row_idx     index of the row on out_row
//   busy            high whenever a job is in progress
//   o_done          one-cycle pulse after the final drain handshake
module systolic_os_array #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K_W    = 8,
  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [K_W-1:0]          i_k_len,
  input  logic                    i_signed,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DATA_W-1:0]  in_left,
  input  logic [COLS*DATA_W-1:0]  in_top,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_row,
  output logic [IDX_W-1:0]        out_row_idx,
  output logic                    busy,
  output logic                    o_done
);

  localparam int unsigned FLUSH_W = $clog2(ROWS + COLS);
  // Two guard bits keep the extended product exact in both signed and unsigned mode.
  localparam int unsigned PROD_W  = 2 * DATA_W + 2;

  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(ROWS + COLS - 1);
  localparam logic [IDX_W-1:0]   LAST_ROW   = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_cnt_q, k_cnt_d;
  logic [FLUSH_W-1:0]  flush_q, flush_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                signed_q, signed_d;
  logic                done_q, done_d;

  logic start_job;
  logic beat;

  assign start_job = (state_q == StIdle) && i_start;
  assign beat      = (state_q == StLoad) && in_valid;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    k_cnt_d  = k_cnt_q;
    flush_d  = flush_q;
    idx_d    = idx_q;
    signed_d = signed_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          signed_d = i_signed;
          k_cnt_d  = i_k_len;
          idx_d    = '0;
          if (i_k_len == '0) begin
            state_d = StFlush;
            flush_d = FLUSH_LAST;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          k_cnt_d = k_cnt_q - K_W'(1);
          if (k_cnt_q == K_W'(1)) begin
            state_d = StFlush;
            flush_d = FLUSH_LAST;
          end
        end
      end
      StFlush: begin
        // One extra cycle after the count expires lets the corner PE settle.
        if (flush_q == '0) begin
          state_d = StDrain;
          idx_d   = '0;
        end else begin
          flush_d = flush_q - FLUSH_W'(1);
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (idx_q == LAST_ROW) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      k_cnt_q  <= '0;
      flush_q  <= '0;
      idx_q    <= '0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_cnt_q  <= k_cnt_d;
      flush_q  <= flush_d;
      idx_q    <= idx_d;
      signed_q <= signed_d;
      done_q   <= done_d;
    end
  end

  assign in_ready    = (state_q == StLoad);
  assign out_valid   = (state_q == StDrain);
  assign busy        = (state_q != StIdle);
  assign o_done      = done_q;
  assign out_row_idx = idx_q;

  // ---------------------------------------------------------------------------
  // Operand network: PE(r,c) inputs, driven by the skew lines at the array edge
  // and by the neighbouring PE's forwarding registers inside the array.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] left_in [ROWS][COLS];
  logic              left_v  [ROWS][COLS];
  logic [DATA_W-1:0] top_in  [ROWS][COLS];
  logic              top_v   [ROWS][COLS];
  logic [ACC_W-1:0]  acc     [ROWS][COLS];

  // Row r: input register plus r delay stages. Bubbles enter as zero with tag 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_left_skew
    logic [DATA_W-1:0] sd_q [r+1];
    logic              sv_q [r+1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i <= r; i++) begin
          sd_q[i] <= '0;
          sv_q[i] <= 1'b0;
        end
      end else if (start_job) begin
        for (int i = 0; i <= r; i++) begin
          sd_q[i] <= '0;
          sv_q[i] <= 1'b0;
        end
      end else begin
        sd_q[0] <= beat ? in_left[r*DATA_W +: DATA_W] : '0;
        sv_q[0] <= beat;
        for (int i = 1; i <= r; i++) begin
          sd_q[i] <= sd_q[i-1];
          sv_q[i] <= sv_q[i-1];
        end
      end
    end

    assign left_in[r][0] = sd_q[r];
    assign left_v[r][0]  = sv_q[r];
  end

  // Column c: input register plus c delay stages.
  for (genvar c = 0; c < COLS; c++) begin : g_top_skew
    logic [DATA_W-1:0] sd_q [c+1];
    logic              sv_q [c+1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i <= c; i++) begin
          sd_q[i] <= '0;
          sv_q[i] <= 1'b0;
        end
      end else if (start_job) begin
        for (int i = 0; i <= c; i++) begin
          sd_q[i] <= '0;
          sv_q[i] <= 1'b0;
        end
      end else begin
        sd_q[0] <= beat ? in_top[c*DATA_W +: DATA_W] : '0;
        sv_q[0] <= beat;
        for (int i = 1; i <= c; i++) begin
          sd_q[i] <= sd_q[i-1];
          sv_q[i] <= sv_q[i-1];
        end
      end
    end

    assign top_in[0][c] = sd_q[c];
    assign top_v[0][c]  = sv_q[c];
  end

  // ---------------------------------------------------------------------------
  // Processing elements
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [PROD_W-1:0] a_x, b_x, prod;
      logic [ACC_W-1:0]         acc_q;

      always_comb begin
        if (signed_q) begin
          a_x = PROD_W'($signed(left_in[r][c]));
          b_x = PROD_W'($signed(top_in[r][c]));
        end else begin
          a_x = PROD_W'(left_in[r][c]);
          b_x = PROD_W'(top_in[r][c]);
        end
        prod = a_x * b_x;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc_q <= '0;
        end else if (start_job) begin
          acc_q <= '0;
        end else if (left_v[r][c] && top_v[r][c]) begin
          // prod is exact, so the cast yields the sign/zero-extended product mod 2^ACC_W.
          acc_q <= acc_q + ACC_W'(prod);
        end
      end

      assign acc[r][c] = acc_q;

      if (c < COLS - 1) begin : g_fwd_right
        logic [DATA_W-1:0] a_q;
        logic              av_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            a_q  <= '0;
            av_q <= 1'b0;
          end else if (start_job) begin
            a_q  <= '0;
            av_q <= 1'b0;
          end else begin
            a_q  <= left_in[r][c];
            av_q <= left_v[r][c];
          end
        end
        assign left_in[r][c+1] = a_q;
        assign left_v[r][c+1]  = av_q;
      end

      if (r < ROWS - 1) begin : g_fwd_down
        logic [DATA_W-1:0] b_q;
        logic              bv_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            b_q  <= '0;
            bv_q <= 1'b0;
          end else if (start_job) begin
            b_q  <= '0;
            bv_q <= 1'b0;
          end else begin
            b_q  <= top_in[r][c];
            bv_q <= top_v[r][c];
          end
        end
        assign top_in[r+1][c] = b_q;
        assign top_v[r+1][c]  = bv_q;
      end
    end
  end

  // Drain mux: only the selected row is presented, and only while draining.
  always_comb begin
    out_row = '0;
    if (state_q == StDrain) begin
      for (int c = 0; c < COLS; c++) begin
        out_row[c*ACC_W +: ACC_W] = acc[idx_q][c];
      end
    end
  end

endmodule

// File: tb/tb_systolic_os_array.sv
// Bench for systolic_os_array (2x2, 16-bit operands, 32-bit accumulators).
// A reference model accumulates C from the accepted beats with plain integer
// arithmetic; a compare process checks every drained row against it, and
// literal expectations pin the model on each directed job.
module tb_systolic_os_array;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int KW   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_start;
  logic [KW-1:0]        i_k_len;
  logic                 i_signed;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_left;
  logic [COLS*DW-1:0]   in_top;
  logic                 out_valid;
  logic                 out_ready;
  logic [COLS*AW-1:0]   out_row;
  logic [0:0]           out_row_idx;
  logic                 busy;
  logic                 o_done;

  systolic_os_array #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DW),
    .ACC_W  (AW),
    .K_W    (KW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_k_len     (i_k_len),
    .i_signed    (i_signed),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_left     (in_left),
    .in_top      (in_top),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .busy        (busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int exp_row = 0;
  bit done_pend = 1'b0;
  logic [AW-1:0] mdl [ROWS][COLS];
  bit mdl_sgn;
  logic [COLS*AW-1:0] got_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] mac(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input bit sgn);
    logic signed [63:0] pa, pb, p;
    pa = sgn ? {{48{a[DW-1]}}, a} : {48'b0, a};
    pb = sgn ? {{48{b[DW-1]}}, b} : {48'b0, b};
    p  = pa * pb;
    return p[AW-1:0];
  endfunction

  function automatic logic [COLS*AW-1:0] model_row(input int r);
    logic [COLS*AW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*AW +: AW] = mdl[r][c];
    return v;
  endfunction

  // Compare process: every drain cycle against the model, o_done every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_row   = 0;
        done_pend = 1'b0;
      end else begin
        chk("o_done", 64'(o_done), 64'(done_pend));
        if (o_done) done_cnt++;
        done_pend = 1'b0;
        if (out_valid) begin
          chk("row_idx", 64'(out_row_idx), 64'(exp_row));
          chk("out_row", out_row, model_row(exp_row));
          if (out_ready) begin
            got_q.push_back(out_row);
            if (exp_row == ROWS - 1) begin
              exp_row   = 0;
              done_pend = 1'b1;
            end else begin
              exp_row++;
            end
          end
        end
      end
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic start_job(input int k, input bit sgn);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = '0;
    mdl_sgn  = sgn;
    done_cnt = 0;
    got_q.delete();
    i_start   = 1'b1;
    i_k_len   = KW'(k);
    i_signed  = sgn;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("ready_after_start", 64'(in_ready), (k != 0) ? 64'd1 : 64'd0);
  endtask

  task automatic send_beat(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                           input logic [DW-1:0] t0, input logic [DW-1:0] t1, input int gap);
    logic [DW-1:0] lv [ROWS];
    logic [DW-1:0] tv [COLS];
    int n;
    lv[0] = l0; lv[1] = l1; tv[0] = t0; tv[1] = t1;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_left  = {l1, l0};
    in_top   = {t1, t0};
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept", 64'(in_ready), 64'd1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = mdl[r][c] + mac(lv[r], tv[c], mdl_sgn);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (!o_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(o_done), 64'd1);
    chk("latency", 64'(cyc - start_cyc), 64'(exp_lat));
    chk("busy_at_done", 64'(busy), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("done_once", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_rows(input string name, input logic [COLS*AW-1:0] r0,
                            input logic [COLS*AW-1:0] r1);
    chk({name, "_count"}, 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk({name, "_row0"}, got_q[0], r0);
      chk({name, "_row1"}, got_q[1], r1);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; i_start = 1'b0; i_k_len = '0; i_signed = 1'b0;
    in_valid = 1'b0; in_left = '0; in_top = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),    64'd0);
    chk("rst_out_valid", 64'(out_valid),   64'd0);
    chk("rst_out_row",   out_row,          64'd0);
    chk("rst_row_idx",   64'(out_row_idx), 64'd0);
    chk("rst_busy",      64'(busy),        64'd0);
    chk("rst_done",      64'(o_done),      64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // A = [[1,2],[3,4]] times identity, unsigned, back to back.
    start_job(2, 1'b0);
    send_beat(16'd1, 16'd3, 16'd1, 16'd0, 0);
    send_beat(16'd2, 16'd4, 16'd0, 16'd1, 0);
    wait_done(8);
    check_rows("ident", {32'd2, 32'd1}, {32'd4, 32'd3});

    // Signed K=1: left {-3,2}, top {5,-7}.
    start_job(1, 1'b1);
    send_beat(16'hFFFD, 16'd2, 16'd5, 16'hFFF9, 0);
    wait_done(7);
    check_rows("signed", {32'h0000_0015, 32'hFFFF_FFF1}, {32'hFFFF_FFF2, 32'h0000_000A});

    // Same bits, unsigned.
    start_job(1, 1'b0);
    send_beat(16'hFFFD, 16'd2, 16'd5, 16'hFFF9, 0);
    wait_done(7);
    check_rows("unsigned", {32'hFFF6_0015, 32'h0004_FFF1}, {32'h0001_FFF2, 32'h0000_000A});

    // K=4 back to back.
    start_job(4, 1'b0);
    send_beat(16'd1, 16'd2, 16'd1, 16'd0, 0);
    send_beat(16'd3, 16'd4, 16'd0, 16'd1, 0);
    send_beat(16'd5, 16'd6, 16'd2, 16'd2, 0);
    send_beat(16'd7, 16'd8, 16'd1, 16'd3, 0);
    chk("k4_ready_low", 64'(in_ready), 64'd0);
    wait_done(10);
    check_rows("k4_b2b", {32'd34, 32'd18}, {32'd40, 32'd22});

    // K=4 with bubbles: in_valid 1,0,0,1,0,0,1,0,0,1.
    start_job(4, 1'b0);
    send_beat(16'd1, 16'd2, 16'd1, 16'd0, 0);
    send_beat(16'd3, 16'd4, 16'd0, 16'd1, 2);
    send_beat(16'd5, 16'd6, 16'd2, 16'd2, 2);
    chk("bubble_still_loading", 64'(in_ready), 64'd1);
    send_beat(16'd7, 16'd8, 16'd1, 16'd3, 2);
    chk("bubble_ready_low", 64'(in_ready), 64'd0);
    wait_done(16);
    check_rows("k4_bubble", {32'd34, 32'd18}, {32'd40, 32'd22});

    // Backpressure on row 1 for 5 cycles, with a stray i_start during drain.
    start_job(2, 1'b0);
    send_beat(16'd1, 16'd3, 16'd1, 16'd0, 0);
    send_beat(16'd2, 16'd4, 16'd0, 16'd1, 0);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_reached", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_idx", 64'(out_row_idx), 64'd1);
      chk("stall_row", out_row, {32'd4, 32'd3});
      i_start = (i == 1);
      i_k_len = KW'(1);
      @(posedge clk); #1;
    end
    i_start   = 1'b0;
    out_ready = 1'b1;
    wait_done(14);
    check_rows("stall", {32'd2, 32'd1}, {32'd4, 32'd3});
    chk("stray_start_ignored", 64'(busy), 64'd0);

    // Wrap: 0xFFFF * 0xFFFF summed twice, modulo 2^32.
    start_job(2, 1'b0);
    send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
    send_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
    wait_done(8);
    check_rows("wrap", {32'hFFFC_0002, 32'hFFFC_0002}, {32'hFFFC_0002, 32'hFFFC_0002});

    // Reset mid-LOAD, then a K=0 job.
    start_job(3, 1'b0);
    send_beat(16'd5, 16'd6, 16'd7, 16'd8, 0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready",  64'(in_ready),    64'd0);
    chk("midrst_out_valid", 64'(out_valid),   64'd0);
    chk("midrst_out_row",   out_row,          64'd0);
    chk("midrst_row_idx",   64'(out_row_idx), 64'd0);
    chk("midrst_busy",      64'(busy),        64'd0);
    chk("midrst_done",      64'(o_done),      64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_busy", 64'(busy), 64'd0);
    chk("after_rst_done", 64'(o_done), 64'd0);
    start_job(0, 1'b0);
    wait_done(6);
    check_rows("k0", 64'd0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
